// File: rtl/ins_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream and writes them to
// instruction memory while holding the core in reset. Optional trailing checksum: INS_LOADER_CHECKSUM_EN.
module ins_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              reload,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [31:0]       W_Ins,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              WE,
  output logic              cpu_RST,
  output logic              load_done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  // One extra bit so the count can reach MAX_WORDS == 2**ADDR_W for the end-of-image compare.
  localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef INS_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD, CHK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD, DONE, ERROR} state_t;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       w_ins_q, w_ins_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic [15:0]       len_new;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept  = byte_valid & ready_q;
  assign len_new = {len_q[15:8], byte_data};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    w_ins_d  = w_ins_q;
    w_addr_d = w_addr_q;
    we_d     = 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (reload) begin
      state_d = LEN_HI;
      idx_d   = 2'd0;
      cnt_d   = '0;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_d  = 8'd0;
`endif
    end else begin
      case (state_q)
        LEN_HI: if (accept) begin
          len_d[15:8] = byte_data;
          state_d     = LEN_LO;
        end
        LEN_LO: if (accept) begin
          len_d = len_new;
          if (len_new == 16'd0 || len_new > 16'(MAX_WORDS)) state_d = ERROR;
          else                                              state_d = WORD;
        end
        WORD: if (accept) begin
          idx_d = idx_q + 2'd1;
          sh_d  = {sh_q[15:0], byte_data};
`ifdef INS_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            w_ins_d  = {sh_q, byte_data};
            w_addr_d = cnt_q[ADDR_W-1:0];
            we_d     = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (16'(cnt_q) + 16'd1 == len_q) begin
`ifdef INS_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end
          end
        end
`ifdef INS_LOADER_CHECKSUM_EN
        CHK: if (accept) begin
          state_d = (byte_data == csum_q) ? DONE : ERROR;
        end
`endif
        default: ;
      endcase
    end

    ready_d   = (state_d != DONE) && (state_d != ERROR);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERROR);
    cpu_rst_d = (state_d != DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= LEN_HI;
      len_q     <= 16'd0;
      idx_q     <= 2'd0;
      sh_q      <= 24'd0;
      cnt_q     <= '0;
      w_ins_q   <= 32'd0;
      w_addr_q  <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      w_ins_q   <= w_ins_d;
      w_addr_q  <= w_addr_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign W_Ins      = w_ins_q;
  assign W_Addr     = w_addr_q;
  assign WE         = we_q;
  assign cpu_RST    = cpu_rst_q;
  assign load_done  = done_q;
  assign err        = err_q;
  assign word_count = cnt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: streams are expanded into expected memory writes at the
// moment bytes are presented; a monitor pops and checks each WE pulse independently.
module tb_ins_loader;

  localparam int unsigned MAXW = 256;
  localparam int unsigned AW   = 8;
`ifdef INS_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST, reload, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, WE, cpu_RST, load_done, err;
  logic [31:0]   W_Ins;
  logic [AW-1:0] W_Addr, word_count;

  ins_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .reload(reload), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .W_Ins(W_Ins), .W_Addr(W_Addr), .WE(WE), .cpu_RST(cpu_RST),
    .load_done(load_done), .err(err), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned addr;
    logic [31:0] word;
    bit          last;
    int unsigned when;
  } exp_t;
  exp_t q[$];

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every WE pulse must match the oldest expected write
  always @(negedge CLK) begin
    if (!RST && WE === 1'b1) begin
      if (q.size() == 0) chk("we_unexpected", 32'(WE), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("w_addr",       32'(W_Addr), 32'(e.addr));
        chk("w_ins",        W_Ins, e.word);
        chk("we_cycle",     cyc, e.when);
        chk("wc_at_we",     32'(word_count), 32'(AW'(e.addr + 1)));
        chk("done_at_we",   32'(load_done), 32'(e.last && !CSUM));
        chk("cpurst_at_we", 32'(cpu_RST), 32'(!(e.last && !CSUM)));
      end
    end
  end

  function automatic bq_t mk(input logic [15:0] n, input wq_t w, input bit csum_ok);
    bq_t s;
    logic [7:0] x;
    x = 8'd0;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    if (n >= 16'd1 && n <= 16'(MAXW)) begin
      foreach (w[i])
        for (int b = 3; b >= 0; b--) begin
          s.push_back(w[i][8*b +: 8]);
          x ^= w[i][8*b +: 8];
        end
      if (CSUM) s.push_back(csum_ok ? x : (x ^ 8'h01));
    end
    return s;
  endfunction

  task automatic check_idle_state(input string tag);
    chk({tag, "_ready"},   32'(byte_ready), 32'd1);
    chk({tag, "_we"},      32'(WE), 32'd0);
    chk({tag, "_cpurst"},  32'(cpu_RST), 32'd1);
    chk({tag, "_done"},    32'(load_done), 32'd0);
    chk({tag, "_err"},     32'(err), 32'd0);
    chk({tag, "_wcount"},  32'(word_count), 32'd0);
  endtask

  // Present the stream; abort_after >= 0 stops after that many bytes (a reload follows).
  task automatic run_stream(input bq_t s, input int gaps, input int abort_after);
    logic [15:0] n;
    bit          ok, exp_done;
    logic [7:0]  x;
    int          k;
    n  = {s[0], s[1]};
    ok = (n >= 16'd1) && (n <= 16'(MAXW));
    for (int i = 0; i < s.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) break;
      if (gaps != 0) begin
        repeat ((gaps == 1) ? 1 : $urandom_range(0, 2)) begin
          @(negedge CLK);
          byte_valid = 1'b0;
          byte_data  = 8'($urandom);
        end
      end
      @(negedge CLK);
      byte_valid = 1'b1;
      byte_data  = s[i];
      chk("byte_ready", 32'(byte_ready), 32'd1);
      k = i - 2;
      if (ok && k >= 0 && k < 4 * int'(n) && (k % 4) == 3)
        q.push_back('{addr: k / 4, word: {s[i-3], s[i-2], s[i-1], s[i]},
                      last: (k / 4 == int'(n) - 1), when: cyc + 1});
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    if (abort_after < 0) begin
      x = 8'd0;
      if (ok) for (int i = 2; i < 2 + 4 * int'(n); i++) x ^= s[i];
      exp_done = ok && (!CSUM || s[s.size() - 1] == x);
      chk("end_done",   32'(load_done), 32'(exp_done));
      chk("end_err",    32'(err), 32'(!exp_done));
      chk("end_cpurst", 32'(cpu_RST), 32'(!exp_done));
      chk("end_ready",  32'(byte_ready), 32'd0);
      chk("end_wcount", 32'(word_count), ok ? 32'(AW'(n)) : 32'd0);
    end
  endtask

  // Bytes offered in DONE/ERROR must be refused and have no effect
  task automatic poke_idle();
    logic d, e;
    d = load_done;
    e = err;
    repeat (3) begin
      @(negedge CLK);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      chk("idle_ready", 32'(byte_ready), 32'd0);
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    chk("idle_done_hold", 32'(load_done), 32'(d));
    chk("idle_err_hold",  32'(err), 32'(e));
  endtask

  task automatic do_reload();
    @(negedge CLK);
    reload     = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge CLK);
    reload     = 1'b0;
    byte_valid = 1'b0;
    check_idle_state("reload");
  endtask

  initial begin
    wq_t w;
    bq_t s;
    int  n, ab;
    RST = 1'b1; reload = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_idle_state("reset");
    chk("reset_wins", W_Ins, 32'd0);
    chk("reset_waddr", 32'(W_Addr), 32'd0);

    // Two-word image, back to back bytes
    w = '{32'h3C080010, 32'h21090005};
    run_stream(mk(16'd2, w, 1'b1), 0, -1);
    poke_idle();

    // Synchronous reset out of DONE
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    check_idle_state("rst_done");
    chk("rst_wins", W_Ins, 32'd0);
    chk("rst_waddr", 32'(W_Addr), 32'd0);

    // Bad lengths
    w = {};
    run_stream(mk(16'd0, w, 1'b1), 0, -1);
    poke_idle();
    do_reload();
    run_stream(mk(16'h0101, w, 1'b1), 0, -1);
    do_reload();

    // Single word with alternating gaps
    w = '{32'hDEADBEEF};
    run_stream(mk(16'd1, w, 1'b1), 1, -1);
    do_reload();

    // Reload after two bytes of the second word drops the partial word
    w = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    run_stream(mk(16'd3, w, 1'b1), 0, 8);
    do_reload();
    w = '{32'hAABBCCDD};
    run_stream(mk(16'd1, w, 1'b1), 0, -1);
    do_reload();

    if (CSUM) begin
      w = '{32'h11223344};
      run_stream(mk(16'd1, w, 1'b1), 0, -1);
      do_reload();
      run_stream(mk(16'd1, w, 1'b0), 0, -1);
      do_reload();
    end

    // Randomized images, lengths, gaps, checksums and aborts
    for (int t = 0; t < 25; t++) begin
      w = {};
      case ($urandom_range(0, 7))
        0:       n = ($urandom_range(0, 1) == 0) ? 0 : int'(MAXW) + 1;
        1:       n = int'($urandom_range(MAXW + 1, 65535));
        default: n = int'($urandom_range(1, 6));
      endcase
      if (n >= 1 && n <= int'(MAXW))
        for (int i = 0; i < n; i++) w.push_back($urandom);
      s  = mk(16'(n), w, $urandom_range(0, 3) != 0);
      ab = -1;
      if (n >= 2 && n <= int'(MAXW) && $urandom_range(0, 4) == 0)
        ab = 2 + 4 * int'($urandom_range(0, n - 1)) + int'($urandom_range(1, 3));
      run_stream(s, 2, ab);
      do_reload();
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
